johnson_phase_tracker: RTL and testbench

- Sits directly downstream of the Johnson counter and consumes its SIZE-bit code every clock.
- Checks each sampled code for legality and sequence continuity, then decodes it to a binary phase index and a one-hot phase vector.
- Declares lock after LOCK_CNT consecutive correct steps and counts full revolutions.
- Feeds phase-driven logic (strobes, multiplexers) and reports counter faults.

---
 rtl/johnson_phase_tracker.sv | 180 ++++++++++++++++++
 tb/tb_johnson_phase_tracker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/johnson_phase_tracker.sv
// rtl/johnson_phase_tracker.sv - Johnson code checker, phase decoder, lock tracker and revolution counter
module johnson_phase_tracker #(
  parameter int SIZE     = 4,
  parameter int LOCK_CNT = 3,
  parameter int CW       = 8,
  localparam int PW      = $clog2(2*SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clear,
  input  logic [SIZE-1:0]     code_in,
  output logic [PW-1:0]       phase,
  output logic [2*SIZE-1:0]   phase_onehot,
  output logic                locked,
  output logic                err_illegal,
  output logic                err_skip,
  output logic                rev_pulse,
  output logic [CW-1:0]       rev_count
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(2*SIZE-1);
  localparam logic [3:0]    LOCK_TGT   = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t              r_state, w_nxt_state;
  logic [PW-1:0]       r_phase, w_nxt_phase;
  logic [3:0]          r_match, w_nxt_match;
  logic                r_err_illegal, w_nxt_err_illegal;
  logic                r_err_skip, w_nxt_err_skip;
  logic                r_rev_pulse, w_nxt_rev_pulse;
  logic [CW-1:0]       r_rev_count, w_nxt_rev_count;
  logic                r_locked, w_nxt_locked;
  logic [2*SIZE-1:0]   r_onehot, w_nxt_onehot;

  logic [PW-1:0]       w_ones;
  logic [SIZE-1:0]     w_pattern;
  logic                w_legal;
  logic [PW-1:0]       w_dec;
  logic [PW-1:0]       w_succ;
  logic                w_is_succ;
  logic                w_is_hold;

  // Legality and decode: rebuild the only legal pattern with this many ones and compare
  always_comb begin
    w_ones    = '0;
    w_pattern = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_ones = w_ones + PW'(code_in[i]);
    end
    for (int i = 0; i < SIZE; i++) begin
      if (code_in[SIZE-1]) begin
        w_pattern[i] = (i >= SIZE - int'(w_ones));
      end else begin
        w_pattern[i] = (i < int'(w_ones));
      end
    end
    w_legal = (code_in == w_pattern);
    if (code_in[SIZE-1]) begin
      w_dec = w_ones;
    end else if (w_ones == '0) begin
      w_dec = '0;
    end else begin
      w_dec = PW'(2*SIZE - int'(w_ones));
    end
    w_succ    = (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
    w_is_succ = (w_dec == w_succ);
    w_is_hold = (w_dec == r_phase);
  end

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_phase       = r_phase;
    w_nxt_match       = r_match;
    w_nxt_err_illegal = r_err_illegal;
    w_nxt_err_skip    = 1'b0;
    w_nxt_rev_pulse   = 1'b0;
    w_nxt_rev_count   = r_rev_count;
    if (clear) begin
      w_nxt_state       = ST_UNLOCK;
      w_nxt_match       = '0;
      w_nxt_err_illegal = 1'b0;
      w_nxt_rev_count   = '0;
    end else if (en) begin
      unique case (r_state)
        ST_UNLOCK: begin
          if (w_legal) begin
            w_nxt_state = ST_TRACK;
            w_nxt_phase = w_dec;
            w_nxt_match = '0;
          end else begin
            w_nxt_state       = ST_FAULT;
            w_nxt_err_illegal = 1'b1;
          end
        end
        ST_TRACK: begin
          if (!w_legal) begin
            w_nxt_state       = ST_FAULT;
            w_nxt_err_illegal = 1'b1;
          end else if (w_is_succ) begin
            w_nxt_phase = w_dec;
            w_nxt_match = r_match + 4'd1;
            if (r_match + 4'd1 == LOCK_TGT) begin
              w_nxt_state = ST_LOCKED;
            end
          end else if (!w_is_hold) begin
            w_nxt_phase = w_dec;
            w_nxt_match = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_legal) begin
            w_nxt_state       = ST_FAULT;
            w_nxt_err_illegal = 1'b1;
          end else if (w_is_succ) begin
            w_nxt_phase = w_dec;
            if (r_phase == LAST_PHASE) begin
              w_nxt_rev_pulse = 1'b1;
              w_nxt_rev_count = r_rev_count + CW'(1);
            end
          end else if (!w_is_hold) begin
            w_nxt_err_skip = 1'b1;
            w_nxt_state    = ST_TRACK;
            w_nxt_match    = '0;
            w_nxt_phase    = w_dec;
          end
        end
        default: begin
          w_nxt_err_illegal = 1'b1;
        end
      endcase
    end
    w_nxt_locked = (w_nxt_state == ST_LOCKED);
    w_nxt_onehot = '0;
    if (w_nxt_locked) begin
      w_nxt_onehot[w_nxt_phase] = 1'b1;
    end
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_UNLOCK;
      r_phase       <= '0;
      r_match       <= '0;
      r_err_illegal <= 1'b0;
      r_err_skip    <= 1'b0;
      r_rev_pulse   <= 1'b0;
      r_rev_count   <= '0;
      r_locked      <= 1'b0;
      r_onehot      <= '0;
    end else begin
      r_state       <= w_nxt_state;
      r_phase       <= w_nxt_phase;
      r_match       <= w_nxt_match;
      r_err_illegal <= w_nxt_err_illegal;
      r_err_skip    <= w_nxt_err_skip;
      r_rev_pulse   <= w_nxt_rev_pulse;
      r_rev_count   <= w_nxt_rev_count;
      r_locked      <= w_nxt_locked;
      r_onehot      <= w_nxt_onehot;
    end
  end

  assign phase        = r_phase;
  assign phase_onehot = r_onehot;
  assign locked       = r_locked;
  assign err_illegal  = r_err_illegal;
  assign err_skip     = r_err_skip;
  assign rev_pulse    = r_rev_pulse;
  assign rev_count    = r_rev_count;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// tb/tb_johnson_phase_tracker.sv - directed self-checking bench for johnson_phase_tracker
module tb_johnson_phase_tracker;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clear;
  logic [3:0] code_in;
  logic [2:0] phase;
  logic [7:0] phase_onehot;
  logic       locked;
  logic       err_illegal;
  logic       err_skip;
  logic       rev_pulse;
  logic [7:0] rev_count;

  int n_cmp;
  int n_bad;
  int pulses;
  logic [3:0] jc_tab [8];

  johnson_phase_tracker #(.SIZE(4), .LOCK_CNT(3), .CW(8)) dut (
    .clk(clk), .reset(reset), .en(en), .clear(clear), .code_in(code_in),
    .phase(phase), .phase_onehot(phase_onehot), .locked(locked),
    .err_illegal(err_illegal), .err_skip(err_skip), .rev_pulse(rev_pulse),
    .rev_count(rev_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one sample, clock it, settle 1ns past the edge
  task automatic step(input logic [3:0] c, input logic e);
    code_in = c;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [2:0] ph, input logic lk,
                           input logic ei, input logic [7:0] rc);
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
    chk({tag, ".err_illegal"}, 32'(err_illegal), 32'(ei));
    chk({tag, ".rev_count"}, 32'(rev_count), 32'(rc));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    jc_tab[0] = 4'b0000; jc_tab[1] = 4'b1000; jc_tab[2] = 4'b1100; jc_tab[3] = 4'b1110;
    jc_tab[4] = 4'b1111; jc_tab[5] = 4'b0111; jc_tab[6] = 4'b0011; jc_tab[7] = 4'b0001;
    reset = 1'b0; en = 1'b0; clear = 1'b0; code_in = 4'b1010;
    @(posedge clk); #1;
    en = 1'b1;
    @(posedge clk); #1;
    chk_state("reset", 3'd0, 1'b0, 1'b0, 8'd0);
    chk("reset.onehot", 32'(phase_onehot), 32'h0);
    chk("reset.pulses", 32'({err_skip, rev_pulse}), 32'h0);
    reset = 1'b1;

    // lock-in: 0001 0000 1000 1100 -> phases 7 0 1 2
    step(4'b0001, 1'b1); chk_state("lock0", 3'd7, 1'b0, 1'b0, 8'd0);
    step(4'b0000, 1'b1); chk_state("lock1", 3'd0, 1'b0, 1'b0, 8'd0);
    chk("lock1.rev_pulse", 32'(rev_pulse), 32'h0);
    step(4'b1000, 1'b1); chk_state("lock2", 3'd1, 1'b0, 1'b0, 8'd0);
    step(4'b1100, 1'b1); chk_state("lock3", 3'd2, 1'b1, 1'b0, 8'd0);
    chk("lock3.onehot", 32'(phase_onehot), 32'h04);

    // revolution: phases 3..7 then 0
    for (int p = 3; p < 8; p++) begin
      step(jc_tab[p], 1'b1);
      chk("rev.no_pulse", 32'(rev_pulse), 32'h0);
    end
    step(4'b0000, 1'b1);
    chk("rev.pulse", 32'(rev_pulse), 32'h1);
    chk_state("rev", 3'd0, 1'b1, 1'b0, 8'd1);
    chk("rev.onehot", 32'(phase_onehot), 32'h01);
    step(4'b1000, 1'b1);
    chk("rev.pulse_end", 32'(rev_pulse), 32'h0);
    step(4'b1100, 1'b1);

    // skip from phase 2 to 4, then relock through 5 6 7
    step(4'b1111, 1'b1);
    chk("skip.err_skip", 32'(err_skip), 32'h1);
    chk_state("skip", 3'd4, 1'b0, 1'b0, 8'd1);
    chk("skip.onehot", 32'(phase_onehot), 32'h0);
    step(4'b0111, 1'b1);
    chk("skip.err_skip_end", 32'(err_skip), 32'h0);
    chk_state("relock1", 3'd5, 1'b0, 1'b0, 8'd1);
    step(4'b0011, 1'b1); chk_state("relock2", 3'd6, 1'b0, 1'b0, 8'd1);
    step(4'b0001, 1'b1); chk_state("relock3", 3'd7, 1'b1, 1'b0, 8'd1);
    chk("relock3.onehot", 32'(phase_onehot), 32'h80);

    // hold three cycles, then en low with wandering codes
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 1'b1);
      chk_state("hold", 3'd7, 1'b1, 1'b0, 8'd1);
      chk("hold.pulses", 32'({err_skip, rev_pulse}), 32'h0);
    end
    step(4'b1010, 1'b0); step(4'b0000, 1'b0); step(4'b0110, 1'b0); step(4'b1100, 1'b0);
    chk_state("engate", 3'd7, 1'b1, 1'b0, 8'd1);
    chk("engate.pulses", 32'({err_skip, rev_pulse}), 32'h0);

    // illegal code enters fault; legal codes ignored; clear recovers
    step(4'b1010, 1'b1);
    chk_state("illegal", 3'd7, 1'b0, 1'b1, 8'd1);
    chk("illegal.onehot", 32'(phase_onehot), 32'h0);
    step(4'b0000, 1'b1); chk_state("fault.hold1", 3'd7, 1'b0, 1'b1, 8'd1);
    step(4'b1000, 1'b1); chk_state("fault.hold2", 3'd7, 1'b0, 1'b1, 8'd1);
    clear = 1'b1;
    step(4'b1000, 1'b1);
    clear = 1'b0;
    chk_state("clear", 3'd7, 1'b0, 1'b0, 8'd0);
    // from UNLOCK: one capture plus three successors to relock
    step(4'b1000, 1'b1); chk_state("unl.cap", 3'd1, 1'b0, 1'b0, 8'd0);
    step(4'b1100, 1'b1); step(4'b1110, 1'b1);
    chk_state("unl.two", 3'd3, 1'b0, 1'b0, 8'd0);
    step(4'b1111, 1'b1); chk_state("unl.lock", 3'd4, 1'b1, 1'b0, 8'd0);

    // 40 successor steps from phase 4: five wraps
    pulses = 0;
    for (int s = 1; s <= 40; s++) begin
      step(jc_tab[(4 + s) % 8], 1'b1);
      if (rev_pulse) pulses++;
    end
    chk("revs.pulses", 32'(pulses), 32'd5);
    chk_state("revs", 3'd4, 1'b1, 1'b0, 8'd5);

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b0;
    #1;
    chk_state("areset", 3'd0, 1'b0, 1'b0, 8'd0);
    chk("areset.onehot", 32'(phase_onehot), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(4'b0000, 1'b1); chk_state("post.cap", 3'd0, 1'b0, 1'b0, 8'd0);
    step(4'b1000, 1'b1); step(4'b1100, 1'b1);
    chk_state("post.two", 3'd2, 1'b0, 1'b0, 8'd0);
    step(4'b1110, 1'b1); chk_state("post.lock", 3'd3, 1'b1, 1'b0, 8'd0);
    chk("post.onehot", 32'(phase_onehot), 32'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
